// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit add through one full-adder cell, LSB first, valid/ready on both sides
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             sbit, cbit, last;
  assign sbit      = a_q[0] ^ b_q[0] ^ c_q;
  assign cbit      = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      c_d     = cin;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d = {sbit, sum_q[WIDTH-1:1]};
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = cbit;
      cnt_d = cnt_q + CW'(1);
      // c_q here is the carry into the MSB, so overflow is its mismatch with the carry out
      if (last) begin
        cout_d  = cbit;
        ovf_d   = cbit ^ c_q;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard bench for WIDTH=8 and WIDTH=16 instances
module tb_bit_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        iv[2], ordy[2], cn[2], ir[2], ov[2], co[2], of[2];
  logic [31:0] av[2], bv[2];
  logic [7:0]  s8;
  logic [15:0] s16;
  int          total = 0, bad = 0;
  bit          auto_rdy = 1'b0;
  bit          force_rdy[2] = '{1'b1, 1'b1};
  logic [33:0] q0[$], q1[$];
  logic [33:0] e_m;
  bit_serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .cin(cn[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s8), .cout(co[0]), .ovf(of[0]));
  bit_serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1][15:0]), .b(bv[1][15:0]),
    .cin(cn[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s16), .cout(co[1]), .ovf(of[1]));

  function automatic int wd(int k);
    return k == 0 ? 8 : 16;
  endfunction
  function automatic logic [31:0] sumv(int k);
    return k == 0 ? {24'b0, s8} : {16'b0, s16};
  endfunction
  // reference: plain integer add, overflow from operand/result signs
  function automatic logic [33:0] model(int k, logic [31:0] x, logic [31:0] y, logic c);
    int w = wd(k);
    logic [32:0] m = (33'd1 << w) - 33'd1;
    logic [32:0] xa = {1'b0, x} & m;
    logic [32:0] ya = {1'b0, y} & m;
    logic [32:0] t = xa + ya + 33'(c);
    logic [31:0] s = t[31:0] & m[31:0];
    logic sov = (xa[w-1] == ya[w-1]) && (s[w-1] != xa[w-1]);
    return {sov, t[w], s};
  endfunction
  function automatic void push(int k, logic [33:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic int qn(int k);
    return k == 0 ? q0.size() : q1.size();
  endfunction
  function automatic logic [33:0] pop(int k);
    return k == 0 ? q0.pop_front() : q1.pop_front();
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: drives out_ready, pops and compares on every taken result
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      ordy[k] = auto_rdy ? ($urandom_range(0, 9) < 7) : force_rdy[k];
      if (rst_n && ov[k] && ordy[k]) begin
        if (qn(k) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result[%0d]: got sum %0h with empty scoreboard", k, sumv(k));
        end else begin
          e_m = pop(k);
          chk($sformatf("sum[%0d]", k), 64'(sumv(k)), 64'(e_m[31:0]));
          chk($sformatf("cout[%0d]", k), 64'(co[k]), 64'(e_m[32]));
          chk($sformatf("ovf[%0d]", k), 64'(of[k]), 64'(e_m[33]));
        end
      end
    end
  end

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(int k, logic [31:0] x, logic [31:0] y, logic c);
    bit ok = 1'b0;
    av[k] = x;
    bv[k] = y;
    cn[k] = c;
    iv[k] = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (ir[k]) begin
        push(k, model(k, x, y, c));
        ok = 1'b1;
      end
      @(negedge clk);
    end
    iv[k] = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout[%0d]: got in_ready=0 expected accept", k);
    end
  endtask
  task automatic wait_ov(int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_vec(logic [7:0] x, logic [7:0] y, logic c, logic [7:0] es, logic ec, logic eo);
    int lat;
    send(0, 32'(x), 32'(y), c);
    wait_ov(0, lat);
    chk("latency", 64'(lat), 64'd8);
    chk("vec_sum", 64'(s8), 64'(es));
    chk("vec_cout", 64'(co[0]), 64'(ec));
    chk("vec_ovf", 64'(of[0]), 64'(eo));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int hits;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      cn[k] = 1'b0;
      av[k] = '0;
      bv[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_sum", 64'(s8), 64'd0);
    chk("rst_cout", 64'(co[0]), 64'd0);
    chk("rst_ovf", 64'(of[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_vec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_vec(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    // backpressure with new operands offered while the result is held
    force_rdy[0] = 1'b0;
    send(0, 32'h55, 32'h2A, 1'b1);
    wait_ov(0, lat);
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1;
      av[0] = $urandom;
      bv[0] = $urandom;
      @(negedge clk);
      chk("bp_in_ready", 64'(ir[0]), 64'd0);
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
      chk("bp_sum", 64'(s8), 64'h80);
      chk("bp_cout_ovf", 64'({co[0], of[0]}), 64'b01);
    end
    iv[0] = 1'b0;
    force_rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(ir[0]), 64'd1);
    chk("bp_release_out_valid", 64'(ov[0]), 64'd0);
    // operands wiggle during RUN; result must use accept-edge values
    send(0, 32'h9C, 32'h3B, 1'b1);
    lat = 0;
    while (!ov[0] && lat < 200) begin
      av[0] = $urandom;
      bv[0] = $urandom;
      cn[0] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("wiggle_sum", 64'(s8), 64'hD8);
    @(negedge clk);
    @(negedge clk);
    // reset after three RUN edges
    send(0, 32'hC3, 32'h5A, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(ir[0]), 64'd1);
    chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
    chk("mid_rst_sum", 64'(s8), 64'd0);
    chk("mid_rst_cout_ovf", 64'({co[0], of[0]}), 64'd0);
    void'(pop(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[0]) hits++;
    end
    chk("mid_rst_no_out_valid", 64'(hits), 64'd0);
    send(0, 32'h12, 32'h34, 1'b0);
    wait_ov(0, lat);
    chk("post_rst_sum", 64'(s8), 64'h46);
    @(negedge clk);
    // random sweep with throttling on both sides
    auto_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(k, $urandom, $urandom, 1'($urandom));
      end
    end
    lat = 0;
    while ((qn(0) != 0 || qn(1) != 0) && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("drain_w8", 64'(qn(0)), 64'd0);
    chk("drain_w16", 64'(qn(1)), 64'd0);
    auto_rdy = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
